axi_full_burst_master: RTL and testbench

- AXI4-Full initiator that writes NUM_BURSTS incrementing-data INCR bursts to a slave, reads them back and compares; the other end of the link from AXI_Full_Slave_Module_Delay, and the stimulus source for that slave in system tops.
- Fixed attributes are tied off by the integrating top: ID=0, SIZE=log2(DATA_WIDTH/8), BURST=INCR, LEN=BURST_LEN-1, WSTRB all ones, LOCK/CACHE/PROT/QOS/USER=0.

---
 rtl/axi_full_burst_master_if.sv | 39 +++
 rtl/axi_full_burst_master.sv | 210 +++++++++++++++++++++
 tb/tb_axi_full_burst_master.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_full_burst_master_if.sv
// AXI4 burst-master link carrying only the channel signals the master varies;
// fixed attributes (ID, SIZE, BURST, LEN, WSTRB, LOCK/CACHE/PROT/QOS/USER) are tied off by the top.
interface axi_full_burst_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic                  M_AXI_AWVALID;
  logic                  M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0] M_AXI_WDATA;
  logic                  M_AXI_WLAST;
  logic                  M_AXI_WVALID;
  logic                  M_AXI_WREADY;
  logic [1:0]            M_AXI_BRESP;
  logic                  M_AXI_BVALID;
  logic                  M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RLAST;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WLAST, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID, M_AXI_ARREADY,
           M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WLAST, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID, M_AXI_ARREADY,
           M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
  );
endinterface

// File: rtl/axi_full_burst_master.sv
// AXI4 INCR burst initiator: writes C_NUM_BURSTS bursts of an incrementing pattern, one at a time.
// Define AXI_FULL_MASTER_CHECK_EN to add the read-back/compare phase; otherwise ERROR reflects BRESP only.
module axi_full_burst_master #(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h40000000,
  parameter int          C_M_AXI_BURST_LEN          = 16,
  parameter int          C_M_AXI_ADDR_WIDTH         = 32,
  parameter int          C_M_AXI_DATA_WIDTH         = 32,
  parameter int          C_NUM_BURSTS               = 4
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          INIT_AXI_TXN,
  output logic                          TXN_DONE,
  output logic                          ERROR,
  axi_full_burst_master_if.master       m_axi
);

  localparam int ADDR_W  = C_M_AXI_ADDR_WIDTH;
  localparam int DATA_W  = C_M_AXI_DATA_WIDTH;
  localparam int BEAT_W  = (C_M_AXI_BURST_LEN > 1) ? $clog2(C_M_AXI_BURST_LEN) : 1;
  localparam int BURST_W = (C_NUM_BURSTS > 1) ? $clog2(C_NUM_BURSTS) : 1;

  localparam logic [BEAT_W-1:0]  LAST_BEAT     = BEAT_W'(C_M_AXI_BURST_LEN - 1);
  localparam logic [BURST_W-1:0] LAST_BURST    = BURST_W'(C_NUM_BURSTS - 1);
  localparam logic [ADDR_W-1:0]  BASE_ADDR     = ADDR_W'(C_M_TARGET_SLAVE_BASE_ADDR);
  localparam logic [ADDR_W-1:0]  BURST_BYTES   = ADDR_W'(C_M_AXI_BURST_LEN * (C_M_AXI_DATA_WIDTH / 8));
  localparam logic [DATA_W-1:0]  PATTERN_START = DATA_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_WR_RESP = 3'd3,
    S_RD_ADDR = 3'd4,
    S_RD_DATA = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t               state_q;
  logic                 init_q;
  logic [BURST_W-1:0]   burst_q;
  logic [BEAT_W-1:0]    beat_q;
  logic [DATA_W-1:0]    pattern_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 awvalid_q;
  logic                 wvalid_q;
  logic                 wlast_q;
  logic                 bready_q;
  logic                 txn_done_q;
  logic                 error_q;
  logic                 start_s;
`ifdef AXI_FULL_MASTER_CHECK_EN
  logic                 arvalid_q;
  logic                 rready_q;
  logic                 rd_bad_s;
`endif

  assign start_s = INIT_AXI_TXN & ~init_q;

`ifdef AXI_FULL_MASTER_CHECK_EN
  // A read beat is bad on data mismatch, error response, or RLAST out of place.
  assign rd_bad_s = (m_axi.M_AXI_RDATA != pattern_q) || (m_axi.M_AXI_RRESP != 2'b00) ||
                    (m_axi.M_AXI_RLAST != (beat_q == LAST_BEAT));
`endif

  // Burst sequencer: one outstanding burst; every AXI output is a register.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q    <= S_IDLE;
      init_q     <= 1'b0;
      burst_q    <= '0;
      beat_q     <= '0;
      pattern_q  <= '0;
      addr_q     <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      bready_q   <= 1'b0;
      txn_done_q <= 1'b0;
      error_q    <= 1'b0;
`ifdef AXI_FULL_MASTER_CHECK_EN
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
`endif
    end else begin
      init_q <= INIT_AXI_TXN;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_s) begin
            burst_q    <= '0;
            beat_q     <= '0;
            pattern_q  <= PATTERN_START;
            addr_q     <= BASE_ADDR;
            awvalid_q  <= 1'b1;
            txn_done_q <= 1'b0;
            error_q    <= 1'b0;
            state_q    <= S_WR_ADDR;
          end
        end
        S_WR_ADDR: begin
          if (m_axi.M_AXI_AWREADY) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= (LAST_BEAT == '0);
            state_q   <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (m_axi.M_AXI_WREADY) begin
            pattern_q <= pattern_q + DATA_W'(1);
            if (beat_q == LAST_BEAT) begin
              beat_q   <= '0;
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= S_WR_RESP;
            end else begin
              beat_q  <= beat_q + BEAT_W'(1);
              wlast_q <= ((beat_q + BEAT_W'(1)) == LAST_BEAT);
            end
          end
        end
        S_WR_RESP: begin
          if (m_axi.M_AXI_BVALID) begin
            bready_q <= 1'b0;
            if (m_axi.M_AXI_BRESP != 2'b00) begin
              error_q <= 1'b1;
            end
            if (burst_q != LAST_BURST) begin
              burst_q   <= burst_q + BURST_W'(1);
              addr_q    <= addr_q + BURST_BYTES;
              awvalid_q <= 1'b1;
              state_q   <= S_WR_ADDR;
            end else begin
`ifdef AXI_FULL_MASTER_CHECK_EN
              burst_q   <= '0;
              pattern_q <= PATTERN_START;
              addr_q    <= BASE_ADDR;
              arvalid_q <= 1'b1;
              state_q   <= S_RD_ADDR;
`else
              txn_done_q <= 1'b1;
              state_q    <= S_DONE;
`endif
            end
          end
        end
`ifdef AXI_FULL_MASTER_CHECK_EN
        S_RD_ADDR: begin
          if (m_axi.M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axi.M_AXI_RVALID) begin
            pattern_q <= pattern_q + DATA_W'(1);
            if (rd_bad_s) begin
              error_q <= 1'b1;
            end
            // The burst ends on our own beat count, not on RLAST.
            if (beat_q == LAST_BEAT) begin
              beat_q   <= '0;
              rready_q <= 1'b0;
              if (burst_q != LAST_BURST) begin
                burst_q   <= burst_q + BURST_W'(1);
                addr_q    <= addr_q + BURST_BYTES;
                arvalid_q <= 1'b1;
                state_q   <= S_RD_ADDR;
              end else begin
                txn_done_q <= 1'b1;
                state_q    <= S_DONE;
              end
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign TXN_DONE            = txn_done_q;
  assign ERROR               = error_q;
  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = pattern_q;
  assign m_axi.M_AXI_WLAST   = wlast_q;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;

`ifdef AXI_FULL_MASTER_CHECK_EN
  assign m_axi.M_AXI_ARADDR  = addr_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;
`else
  logic unused_rd_s;
  assign unused_rd_s = ^{m_axi.M_AXI_ARREADY, m_axi.M_AXI_RDATA, m_axi.M_AXI_RRESP,
                         m_axi.M_AXI_RLAST, m_axi.M_AXI_RVALID};
  assign m_axi.M_AXI_ARADDR  = '0;
  assign m_axi.M_AXI_ARVALID = 1'b0;
  assign m_axi.M_AXI_RREADY  = 1'b0;
`endif

endmodule

// File: tb/tb_axi_full_burst_master.sv
// Randomized bench for axi_full_burst_master: a stalling memory slave plus a queue-based
// model of the expected AW addresses, W beats and final ERROR/TXN_DONE state.
module tb_axi_full_burst_master;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          LEN  = 16;
  localparam int          NB   = 4;
  localparam logic [31:0] BASE = 32'h40000000;
  localparam int          BYTES = LEN * DW / 8;
`ifdef AXI_FULL_MASTER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init = 1'b0;
  logic txn_done;
  logic error;

  axi_full_burst_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_full_burst_master #(
    .C_M_TARGET_SLAVE_BASE_ADDR(BASE),
    .C_M_AXI_BURST_LEN(LEN),
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .C_NUM_BURSTS(NB)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESETN(rst_n),
    .INIT_AXI_TXN(init),
    .TXN_DONE(txn_done),
    .ERROR(error),
    .m_axi(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave configuration and model state
  bit  stall_en = 1'b0;
  bit  corrupt_en = 1'b0;
  int  err_burst = -1;
  logic [63:0] exp_aw[$];
  logic [63:0] exp_wd[$];
  bit          exp_wl[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] ar_q[$];
  logic [AW-1:0] cur_waddr;
  int  cyc = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int  w_beat = 0, r_beat = 0, b_owed = 0, last_b_cyc = 0, done_cyc = 0;
  bit  b_taken, r_taken, p_awv, p_wv, p_arv, done_prev;
  logic [63:0] p_awa, p_wd, p_ara;

  function automatic bit rdy();
    return !stall_en || ($urandom_range(0, 2) == 0);
  endfunction

  // Slave: drives on the falling edge, predicts the handshakes of the next rising edge.
  always @(negedge clk) begin : slave
    logic [AW-1:0] ra;
    cyc++;
    if (!rst_n) begin
      bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_ARREADY = 1'b0;
      bus.M_AXI_BVALID = 1'b0; bus.M_AXI_BRESP = 2'b00;
      bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RDATA = '0; bus.M_AXI_RRESP = 2'b00; bus.M_AXI_RLAST = 1'b0;
      b_owed = 0; w_beat = 0; r_beat = 0; ar_q.delete();
      b_taken = 1'b0; r_taken = 1'b0; p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0; done_prev = 1'b0;
    end else begin
      if (b_taken) begin bus.M_AXI_BVALID = 1'b0; b_taken = 1'b0; end
      if (r_taken) begin bus.M_AXI_RVALID = 1'b0; r_taken = 1'b0; end
      if (txn_done && !done_prev) done_cyc = cyc;
      done_prev = txn_done;
      if (p_awv) begin
        check("aw_valid_held", 64'(bus.M_AXI_AWVALID), 64'd1);
        check("aw_addr_held", 64'(bus.M_AXI_AWADDR), p_awa);
      end
      if (p_wv) begin
        check("w_valid_held", 64'(bus.M_AXI_WVALID), 64'd1);
        check("w_payload_held", 64'({bus.M_AXI_WLAST, bus.M_AXI_WDATA}), p_wd);
      end
      if (p_arv) begin
        check("ar_valid_held", 64'(bus.M_AXI_ARVALID), 64'd1);
        check("ar_addr_held", 64'(bus.M_AXI_ARADDR), p_ara);
      end
      bus.M_AXI_AWREADY = rdy();
      bus.M_AXI_WREADY  = rdy();
      bus.M_AXI_ARREADY = rdy();
      if (!bus.M_AXI_BVALID && b_owed > 0 && rdy()) begin
        bus.M_AXI_BVALID = 1'b1;
        bus.M_AXI_BRESP  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
      end
      if (!bus.M_AXI_RVALID && ar_q.size() > 0 && rdy()) begin
        ra = ar_q[0] + AW'(r_beat * (DW / 8));
        bus.M_AXI_RDATA = mem.exists(ra) ? mem[ra] : '0;
        if (corrupt_en && r_cnt == 20) bus.M_AXI_RDATA = '0;
        bus.M_AXI_RLAST  = (r_beat == LEN - 1);
        bus.M_AXI_RRESP  = 2'b00;
        bus.M_AXI_RVALID = 1'b1;
      end
      p_awv = bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY; p_awa = 64'(bus.M_AXI_AWADDR);
      p_wv  = bus.M_AXI_WVALID && !bus.M_AXI_WREADY;   p_wd  = 64'({bus.M_AXI_WLAST, bus.M_AXI_WDATA});
      p_arv = bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY; p_ara = 64'(bus.M_AXI_ARADDR);
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
        check("aw_expected", 64'(exp_aw.size() > 0), 64'd1);
        if (exp_aw.size() > 0) check("aw_addr", 64'(bus.M_AXI_AWADDR), exp_aw.pop_front());
        aw_cnt++; cur_waddr = bus.M_AXI_AWADDR; w_beat = 0;
      end
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
        check("w_expected", 64'(exp_wd.size() > 0), 64'd1);
        if (exp_wd.size() > 0) begin
          check("w_data", 64'(bus.M_AXI_WDATA), exp_wd.pop_front());
          check("w_last", 64'(bus.M_AXI_WLAST), 64'(exp_wl.pop_front()));
        end
        mem[cur_waddr + AW'(w_beat * (DW / 8))] = bus.M_AXI_WDATA;
        w_beat++; w_cnt++;
        if (bus.M_AXI_WLAST) b_owed++;
      end
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
        b_cnt++; b_owed--; b_taken = 1'b1; last_b_cyc = cyc;
      end
      if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
        check("ar_addr", 64'(bus.M_AXI_ARADDR), 64'(BASE + AW'(ar_cnt * BYTES)));
        ar_q.push_back(bus.M_AXI_ARADDR); ar_cnt++;
      end
      if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) begin
        r_cnt++; r_taken = 1'b1;
        if (r_beat == LEN - 1) begin r_beat = 0; void'(ar_q.pop_front()); end
        else r_beat++;
      end
    end
  end

  task automatic start_txn(input bit stall, input int err_b, input bit corrupt);
    logic [AW-1:0] a;
    stall_en = stall; err_burst = err_b; corrupt_en = corrupt;
    exp_aw.delete(); exp_wd.delete(); exp_wl.delete();
    for (int n = 0; n < NB; n++) begin
      a = BASE + AW'(n * BYTES);
      exp_aw.push_back(64'(a));
      for (int b = 0; b < LEN; b++) begin
        exp_wd.push_back(64'(n * LEN + b + 1));
        exp_wl.push_back(b == LEN - 1);
      end
    end
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; last_b_cyc = 0; done_cyc = 0;
    init = 1'b1;
    @(negedge clk); #1;
    init = 1'b0;
  endtask

  task automatic finish_txn(input bit extra_pulse, input bit exp_err);
    bit seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk); #1;
      if (extra_pulse && i == 20) init = 1'b1;
      if (extra_pulse && i == 21) init = 1'b0;
      seen = txn_done;
    end
    init = 1'b0;
    check("done_in_time", 64'(seen), 64'd1);
    check("error_flag", 64'(error), 64'(exp_err));
    check("aw_count", 64'(aw_cnt), 64'(NB));
    check("w_count", 64'(w_cnt), 64'(NB * LEN));
    check("b_count", 64'(b_cnt), 64'(NB));
    check("ar_count", 64'(ar_cnt), CHK ? 64'(NB) : 64'd0);
    check("r_count", 64'(r_cnt), CHK ? 64'(NB * LEN) : 64'd0);
    check("w_left", 64'(exp_wd.size()), 64'd0);
`ifndef AXI_FULL_MASTER_CHECK_EN
    check("done_latency", 64'(done_cyc - last_b_cyc), 64'd1);
`endif
  endtask

  task automatic run_txn(input bit stall, input int err_b, input bit corrupt, input bit extra);
    start_txn(stall, err_b, corrupt);
    finish_txn(extra, (err_b >= 0 && err_b < NB) || (CHK && corrupt));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, 64'({txn_done, error, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WLAST,
                                bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY}), 64'd0);
    check({tag, "_awaddr"}, 64'(bus.M_AXI_AWADDR), 64'd0);
    check({tag, "_wdata"}, 64'(bus.M_AXI_WDATA), 64'd0);
    check({tag, "_araddr"}, 64'(bus.M_AXI_ARADDR), 64'd0);
  endtask

  initial begin
    bit hit;
    int eb;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk); #1;

    run_txn(1'b0, -1, 1'b0, 1'b0);   // always-ready slave, clean
    run_txn(1'b1, -1, 1'b0, 1'b1);   // stalls plus an ignored mid-run start
    run_txn(1'b1, 2, 1'b0, 1'b0);    // BRESP error on burst 2
    run_txn(1'b1, -1, 1'b0, 1'b0);   // restart clears ERROR
    if (CHK) begin
      run_txn(1'b0, -1, 1'b1, 1'b0); // read beat 20 corrupted
      run_txn(1'b0, -1, 1'b0, 1'b0);
    end

    // Reset in the middle of a write burst
    start_txn(1'b0, -1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk); #1;
      hit = (w_cnt >= 8) && bus.M_AXI_WVALID;
    end
    check("reached_beat7", 64'(hit), 64'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    run_txn(1'b1, -1, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      eb = int'($urandom_range(0, NB));
      run_txn(1'($urandom_range(0, 1)), (eb == NB) ? -1 : eb, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
